// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive adapter: speed codes, FSM state
// encodings, preamble/SFD nibbles and in-band status bit positions.
package rgmii_pkg;

  // speed_selection / in-band speed codes (bit 1 set means gigabit)
  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  // Receive FSM state encodings
  localparam logic [2:0] ST_DROP     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_PREAMBLE = 3'd2;
  localparam logic [2:0] ST_DATA_LO  = 3'd3;
  localparam logic [2:0] ST_DATA_HI  = 3'd4;

  // 10/100 preamble and start-of-frame nibbles
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // In-band status bit positions within the IFG nibble
  localparam int unsigned STAT_LINK_BIT   = 0;
  localparam int unsigned STAT_SPEED_LSB  = 1;
  localparam int unsigned STAT_SPEED_MSB  = 2;
  localparam int unsigned STAT_DUPLEX_BIT = 3;

  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } inband_status_t;

  // Any speed code with bit 1 set selects the byte-per-cycle path
  function automatic logic speed_is_gig(input logic [1:0] spd);
    return (spd & SPD_1000) != 2'b00;
  endfunction

  function automatic inband_status_t decode_status(input logic [3:0] nib);
    inband_status_t st;
    st.link   = nib[STAT_LINK_BIT];
    st.speed  = nib[STAT_SPEED_MSB:STAT_SPEED_LSB];
    st.duplex = nib[STAT_DUPLEX_BIT];
    return st;
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// RGMII in-band status decoder: samples the IFG nibble and only updates the
// link outputs once SYNC_FILT consecutive identical samples have been seen.
module rgmii_inband_status #(
  parameter int unsigned SYNC_FILT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [3:0] sample,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex
);
  import rgmii_pkg::*;

  localparam logic [2:0] FILT_LEN = 3'(SYNC_FILT);

  logic [3:0]     cand;
  logic [2:0]     run;
  logic [2:0]     run_nxt;
  inband_status_t st;

  // Length of the current run of identical samples, saturating at FILT_LEN
  always_comb begin
    run_nxt = run;
    st      = decode_status(sample);
    if (sample_en) begin
      if (sample != cand) begin
        run_nxt = 3'd1;
      end else if (run < FILT_LEN) begin
        run_nxt = run + 3'd1;
      end
    end
  end

  // Candidate/run tracking and filtered status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cand        <= '0;
      run         <= '0;
      link_up     <= 1'b0;
      link_speed  <= '0;
      link_duplex <= 1'b0;
    end else begin
      run <= run_nxt;
      if (sample_en) begin
        cand <= sample;
        if (run_nxt == FILT_LEN) begin
          link_up     <= st.link;
          link_speed  <= st.speed;
          link_duplex <= st.duplex;
        end
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_adapter.sv
// RGMII receive adapter: turns per-cycle IDDR outputs into a byte-wide GMII
// stream with byte strobe. Gigabit passes bytes straight through; 10/100
// pairs nibbles, aligns on SFD and flags dribble (odd-nibble) endings.
// Keeps saturating frame/error counters.
// Optional in-band status decoding: define RGMII_RX_INBAND_STATUS_EN.
module rgmii_rx_adapter #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SYNC_FILT = 2
) (
  input  logic             gmii_rx_clk,
  input  logic             reset,
  input  logic [3:0]       rxd_rise,
  input  logic [3:0]       rxd_fall,
  input  logic             ctl_rise,
  input  logic             ctl_fall,
  input  logic [1:0]       speed_selection,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_ce,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic             dribble_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex
);
  import rgmii_pkg::*;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] speed_r;
  logic       pair;
  logic       pair_nxt;
  logic [3:0] lo_nib;
  logic [3:0] lo_nib_nxt;
  logic       lo_er;
  logic       lo_er_nxt;
  logic       frame_err;

  logic [7:0] rxd_nxt;
  logic       ce_nxt;
  logic       er_nxt;
  logic       dv_nxt;
  logic       drib_nxt;
  logic       dv_fall;
  logic [3:0] nib;
  logic       nib_er;
  logic       gig;

  assign nib     = rxd_rise;
  assign nib_er  = ctl_rise ^ ctl_fall;
  assign gig     = speed_is_gig(speed_r);
  assign dv_fall = gmii_rx_dv && !dv_nxt;

  // Next-state and next-output decode for both speed families
  always_comb begin
    state_nxt  = state;
    pair_nxt   = pair;
    lo_nib_nxt = lo_nib;
    lo_er_nxt  = lo_er;
    rxd_nxt    = gmii_rxd;
    ce_nxt     = 1'b0;
    er_nxt     = 1'b0;
    dv_nxt     = gmii_rx_dv;
    drib_nxt   = 1'b0;

    case (state)
      ST_DROP: begin
        dv_nxt = 1'b0;
        if (!ctl_rise) state_nxt = ST_IDLE;
      end

      ST_IDLE: begin
        dv_nxt   = 1'b0;
        pair_nxt = 1'b0;
        if (ctl_rise) begin
          if (gig) begin
            // Gigabit reuses DATA_HI as its in-frame state
            rxd_nxt   = {rxd_fall, rxd_rise};
            ce_nxt    = 1'b1;
            er_nxt    = nib_er;
            dv_nxt    = 1'b1;
            state_nxt = ST_DATA_HI;
          end else begin
            state_nxt = ST_PREAMBLE;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!ctl_rise) begin
          dv_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end else if (nib == PREAMBLE_NIB) begin
          pair_nxt = !pair;
          if (pair) begin
            rxd_nxt = {PREAMBLE_NIB, PREAMBLE_NIB};
            ce_nxt  = 1'b1;
            er_nxt  = nib_er;
            dv_nxt  = 1'b1;
          end
        end else if (nib == SFD_NIB) begin
          // SFD realigns the nibble pairing regardless of preamble parity
          rxd_nxt   = {SFD_NIB, PREAMBLE_NIB};
          ce_nxt    = 1'b1;
          er_nxt    = nib_er;
          dv_nxt    = 1'b1;
          state_nxt = ST_DATA_LO;
        end else begin
          rxd_nxt   = {nib, PREAMBLE_NIB};
          ce_nxt    = 1'b1;
          er_nxt    = 1'b1;
          dv_nxt    = 1'b1;
          state_nxt = ST_DATA_LO;
        end
      end

      ST_DATA_LO: begin
        if (!ctl_rise) begin
          dv_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          lo_nib_nxt = nib;
          lo_er_nxt  = nib_er;
          state_nxt  = ST_DATA_HI;
        end
      end

      ST_DATA_HI: begin
        if (gig) begin
          if (ctl_rise) begin
            rxd_nxt = {rxd_fall, rxd_rise};
            ce_nxt  = 1'b1;
            er_nxt  = nib_er;
            dv_nxt  = 1'b1;
          end else begin
            dv_nxt    = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else if (ctl_rise) begin
          rxd_nxt   = {nib, lo_nib};
          ce_nxt    = 1'b1;
          er_nxt    = nib_er | lo_er;
          dv_nxt    = 1'b1;
          state_nxt = ST_DATA_LO;
        end else begin
          // Odd nibble count: flush the lone low nibble as an errored byte;
          // dv drops on the following cycle from IDLE
          rxd_nxt   = {4'h0, lo_nib};
          ce_nxt    = 1'b1;
          er_nxt    = 1'b1;
          dv_nxt    = 1'b1;
          drib_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        dv_nxt    = 1'b0;
        state_nxt = ST_DROP;
      end
    endcase
  end

  // FSM, output registers and speed latch
  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      state       <= ST_DROP;
      speed_r     <= SPD_10;
      pair        <= 1'b0;
      lo_nib      <= '0;
      lo_er       <= 1'b0;
      gmii_rxd    <= '0;
      gmii_rx_ce  <= 1'b0;
      gmii_rx_er  <= 1'b0;
      gmii_rx_dv  <= 1'b0;
      dribble_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pair        <= pair_nxt;
      lo_nib      <= lo_nib_nxt;
      lo_er       <= lo_er_nxt;
      gmii_rxd    <= rxd_nxt;
      gmii_rx_ce  <= ce_nxt;
      gmii_rx_er  <= er_nxt;
      gmii_rx_dv  <= dv_nxt;
      dribble_err <= drib_nxt;
      if (state == ST_IDLE && !ctl_rise) speed_r <= speed_selection;
    end
  end

  // Frame statistics, counted on the falling edge of dv
  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (dv_fall) begin
        frame_err <= 1'b0;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
        if (frame_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (ce_nxt && er_nxt) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic ifg_sample;

  assign ifg_sample = (state == ST_IDLE) && !ctl_rise && !ctl_fall;

  rgmii_inband_status #(
    .SYNC_FILT (SYNC_FILT)
  ) u_inband_status (
    .clk         (gmii_rx_clk),
    .reset       (reset),
    .sample_en   (ifg_sample),
    .sample      (rxd_rise),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );
`else
  assign link_up     = 1'b0;
  assign link_speed  = 2'b00;
  assign link_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_adapter.sv
// Self-checking bench for rgmii_rx_adapter: a vector table drives the input
// pins cycle by cycle, expected bytes go to a scoreboard when driven and are
// popped when the DUT strobes ce; table rows may also check dv/dribble and
// counters. Counters are 2 bits wide here so saturation is reached.
module tb_rgmii_rx_adapter;

`ifdef RGMII_RX_INBAND_STATUS_EN
  localparam bit INBAND = 1'b1;
`else
  localparam bit INBAND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rxd_rise;
  logic [3:0] rxd_fall;
  logic       ctl_rise;
  logic       ctl_fall;
  logic [1:0] speed_selection;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_ce;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       dribble_err;
  logic [1:0] frame_cnt;
  logic [1:0] err_cnt;
  logic       link_up;
  logic [1:0] link_speed;
  logic       link_duplex;

  rgmii_rx_adapter #(
    .CNT_W     (2),
    .SYNC_FILT (2)
  ) dut (
    .gmii_rx_clk     (clk),
    .reset           (reset),
    .rxd_rise        (rxd_rise),
    .rxd_fall        (rxd_fall),
    .ctl_rise        (ctl_rise),
    .ctl_fall        (ctl_fall),
    .speed_selection (speed_selection),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_ce      (gmii_rx_ce),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .dribble_err     (dribble_err),
    .frame_cnt       (frame_cnt),
    .err_cnt         (err_cnt),
    .link_up         (link_up),
    .link_speed      (link_speed),
    .link_duplex     (link_duplex)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned drib_seen = 0;

  logic [7:0]  sb_byte[$];
  logic        sb_er[$];
  int unsigned sb_due[$];

  // One row = inputs for one cycle, an optional expected byte (output one
  // cycle later), and optional checks of the outputs during that same cycle.
  typedef struct {
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        cr;
    logic        cf;
    logic [1:0]  spd;
    logic        push;
    logic [7:0]  byt;
    logic        er;
    logic        chk;
    logic        dv;
    logic        drib;
    int unsigned fcnt;
    int unsigned ecnt;
  } vec_t;

  vec_t        vecs[$];
  logic        pend_chk = 1'b0;
  logic        pend_dv, pend_drib;
  int unsigned pend_f, pend_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int unsigned sat(input int unsigned n);
    return (n > 3) ? 3 : n;
  endfunction

  // Scoreboard consumer: every ce byte must match the oldest expected entry
  always @(negedge clk) begin
    if (dribble_err === 1'b1) drib_seen++;
    if (gmii_rx_ce === 1'b1) begin
      check("ce_with_dv", 32'(gmii_rx_dv), 32'd1);
      if (sb_byte.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ce actual=0x%0h required=no_byte (cycle %0d)", gmii_rxd, cyc);
      end else begin
        check("rx_byte", 32'(gmii_rxd), 32'(sb_byte.pop_front()));
        check("rx_er", 32'(gmii_rx_er), 32'(sb_er.pop_front()));
        check("rx_latency", cyc, sb_due.pop_front());
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf,
                       input logic [1:0] spd, input logic push, input logic [7:0] b, input logic e);
    @(posedge clk);
    #1;
    rxd_rise        = r;
    rxd_fall        = f;
    ctl_rise        = cr;
    ctl_fall        = cf;
    speed_selection = spd;
    if (push) begin
      sb_byte.push_back(b);
      sb_er.push_back(e);
      sb_due.push_back(cyc + 1);
    end
  endtask

  // ---- table builders ----
  task automatic expect_now(input logic dv, input logic drib, input int unsigned f, input int unsigned e);
    pend_chk  = 1'b1;
    pend_dv   = dv;
    pend_drib = drib;
    pend_f    = sat(f);
    pend_e    = sat(e);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf,
                     input logic [1:0] spd, input logic push, input logic [7:0] b, input logic e);
    vec_t v;
    v.rise = r; v.fall = f; v.cr = cr; v.cf = cf; v.spd = spd;
    v.push = push; v.byt = b; v.er = e;
    v.chk = pend_chk; v.dv = pend_dv; v.drib = pend_drib; v.fcnt = pend_f; v.ecnt = pend_e;
    pend_chk = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [1:0] spd);
    add(4'h0, 4'h0, 1'b0, 1'b0, spd, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic gig(input logic [3:0] r, input logic [3:0] f, input logic cf);
    add(r, f, 1'b1, cf, 2'b10, 1'b1, {f, r}, !cf);
  endtask

  task automatic nib(input logic [3:0] r, input logic [1:0] spd, input logic push,
                     input logic [7:0] b, input logic e, input logic cf);
    add(r, 4'h0, 1'b1, cf, spd, push, b, e);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; rxd_rise = 4'h5; rxd_fall = 4'h5;
    ctl_rise = 1'b1; ctl_fall = 1'b1; speed_selection = 2'b10;

    // Frame 1: gigabit, seven 0x55 + 0xD5, then data with one er byte
    expect_now(1'b0, 1'b0, 0, 0); idle(2'b10);
    idle(2'b10); idle(2'b10);
    for (int i = 0; i < 7; i++) gig(4'h5, 4'h5, 1'b1);
    gig(4'h5, 4'hD, 1'b1);
    gig(4'h3, 4'hC, 1'b1);
    gig(4'h9, 4'h1, 1'b0);
    gig(4'hE, 4'h7, 1'b1);
    expect_now(1'b1, 1'b0, 0, 0); idle(2'b01);
    expect_now(1'b0, 1'b0, 1, 1); idle(2'b01);

    // Frame 2: 100 Mb/s, 15 preamble nibbles (first taken in IDLE), SFD, 0xA3
    nib(4'h5, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 14; i++) nib(4'h5, 2'b01, (i % 2) == 0, 8'h55, 1'b0, 1'b1);
    nib(4'hD, 2'b01, 1'b1, 8'hD5, 1'b0, 1'b1);
    nib(4'h3, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'hA, 2'b01, 1'b1, 8'hA3, 1'b0, 1'b1);
    expect_now(1'b1, 1'b0, 1, 1); idle(2'b01);
    expect_now(1'b0, 1'b0, 2, 1); idle(2'b01);

    // Frame 3: 100 Mb/s ending after odd nibble 0x7 (dribble)
    nib(4'h5, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h5, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h5, 2'b01, 1'b1, 8'h55, 1'b0, 1'b1);
    nib(4'hD, 2'b01, 1'b1, 8'hD5, 1'b0, 1'b1);
    nib(4'h3, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'hA, 2'b01, 1'b1, 8'hA3, 1'b0, 1'b1);
    nib(4'h7, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    add(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h07, 1'b1);
    expect_now(1'b1, 1'b1, 2, 1); idle(2'b00);
    expect_now(1'b0, 1'b0, 3, 2); idle(2'b00);

    // Frame 4: 10 Mb/s, odd preamble count, speed pin flips to 1x mid-frame
    nib(4'h5, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h5, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h5, 2'b10, 1'b1, 8'h55, 1'b0, 1'b1);
    nib(4'h5, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'hD, 2'b10, 1'b1, 8'hD5, 1'b0, 1'b1);
    nib(4'h2, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h1, 2'b10, 1'b1, 8'h12, 1'b0, 1'b1);
    nib(4'h4, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h8, 2'b10, 1'b1, 8'h84, 1'b0, 1'b1);
    expect_now(1'b1, 1'b0, 3, 2); idle(2'b10);
    expect_now(1'b0, 1'b0, 4, 2); idle(2'b10);
    idle(2'b10);

    // Frame 5: gigabit now in effect after IDLE
    gig(4'hF, 4'h0, 1'b1);
    expect_now(1'b1, 1'b0, 4, 2); idle(2'b01);
    expect_now(1'b0, 1'b0, 5, 2); idle(2'b01);

    // Carrier extend / false carrier outside a frame
    for (int i = 0; i < 3; i++) add(4'hF, 4'hF, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0);
    expect_now(1'b0, 1'b0, 5, 2); idle(2'b01);

    // Frame 6: 100 Mb/s, bad preamble nibble, errored low data nibble
    nib(4'h5, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h5, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    nib(4'h9, 2'b01, 1'b1, 8'h95, 1'b1, 1'b1);
    nib(4'h1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    nib(4'h2, 2'b01, 1'b1, 8'h21, 1'b1, 1'b1);
    expect_now(1'b1, 1'b0, 5, 2); idle(2'b10);
    expect_now(1'b0, 1'b0, 6, 3); idle(2'b10);

    // Frame 7: gigabit errored byte, err_cnt stays saturated
    gig(4'h0, 4'h0, 1'b0);
    expect_now(1'b1, 1'b0, 6, 3); idle(2'b10);
    expect_now(1'b0, 1'b0, 7, 4); idle(2'b10);
    idle(2'b10); idle(2'b10);

    // Reset asserted and released mid-frame: nothing may come out
    for (int i = 0; i < 3; i++) drive(4'h5, 4'h5, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("rst_rxd", 32'(gmii_rxd), 32'd0);
    check("rst_ce", 32'(gmii_rx_ce), 32'd0);
    check("rst_dv", 32'(gmii_rx_dv), 32'd0);
    check("rst_er", 32'(gmii_rx_er), 32'd0);
    check("rst_dribble", 32'(dribble_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_link", 32'({link_up, link_speed, link_duplex}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'h5, 4'h5, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rise, v.fall, v.cr, v.cf, v.spd, v.push, v.byt, v.er);
      @(negedge clk);
      if (v.chk) begin
        check($sformatf("row%0d_dv", i), 32'(gmii_rx_dv), 32'(v.dv));
        check($sformatf("row%0d_dribble", i), 32'(dribble_err), 32'(v.drib));
        check($sformatf("row%0d_frame_cnt", i), 32'(frame_cnt), v.fcnt);
        check($sformatf("row%0d_err_cnt", i), 32'(err_cnt), v.ecnt);
      end
    end

    // In-band status: two IFG samples of 0xD, then a one-cycle 0x0 glitch
    drive(4'hD, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    drive(4'hD, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("link_one_sample", 32'(link_up), 32'd0);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("link_up", 32'(link_up), 32'(INBAND));
    check("link_speed", 32'(link_speed), INBAND ? 32'd2 : 32'd0);
    check("link_duplex", 32'(link_duplex), 32'(INBAND));
    drive(4'hD, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("glitch_link", 32'({link_up, link_speed, link_duplex}), INBAND ? 32'hD : 32'd0);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("after_glitch_link", 32'({link_up, link_speed, link_duplex}), INBAND ? 32'hD : 32'd0);

    for (int i = 0; i < 3; i++) drive(4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("sb_drained", 32'(sb_byte.size()), 32'd0);
    check("dribble_pulses", drib_seen, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
